fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues SRAM-like instruction requests and buffers
// the returned words in a small in-order queue that feeds the decoder.
// Redirects flush the queue and discard every response still in flight.
// Optional macro FETCH_BYPASS_EN: forward a returning word straight to the
// decoder in the same cycle when the queue is empty.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;

    typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic            w_in_hold;
    logic            r_req;
    logic [31:0]     r_fpc, r_hold_pc;
    logic [CW-1:0]   r_out_cnt, r_q_cnt, r_dc;
    logic [CW-1:0]   w_out_nxt, w_q_nxt, w_dc_nxt;
    logic [CW:0]     w_sum;
    logic            w_room;
    // PC FIFO of accepted request addresses, popped on every response
    logic [31:0]     r_pcf [QDEPTH];
    logic [AW-1:0]   r_pf_wp, r_pf_rp;
    // instruction queue
    logic [31:0]     r_qpc  [QDEPTH];
    logic [31:0]     r_qins [QDEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic            w_acc, w_drop, w_keep, w_q_empty, w_push, w_pop, w_byp;
    logic [31:0]     w_head_pc;

    assign w_acc     = r_req & inst_addr_ok;
    assign w_drop    = redirect_valid | (r_dc != '0);
    assign w_keep    = inst_data_ok & ~w_drop;
    assign w_q_empty = (r_q_cnt == '0);
    assign w_head_pc = r_pcf[r_pf_rp];

`ifdef FETCH_BYPASS_EN
    assign w_byp  = w_keep & w_q_empty;
    assign w_push = w_keep & ~(w_byp & dec_ready);
`else
    assign w_byp  = 1'b0;
    assign w_push = w_keep;
`endif

    assign w_pop     = dec_valid & dec_ready & ~w_byp;
    assign w_out_nxt = r_out_cnt + CW'(w_acc) - CW'(inst_data_ok);
    assign w_q_nxt   = redirect_valid ? '0 : (r_q_cnt + CW'(w_push) - CW'(w_pop));
    // Discard count covers everything outstanding at the redirect, plus a stale
    // held request that gets accepted later while in HOLD.
    assign w_dc_nxt  = redirect_valid ? w_out_nxt :
                       (r_dc - CW'(inst_data_ok && (r_dc != '0)) + CW'(w_acc && w_in_hold));
    // Only request when a queue slot is guaranteed for the response.
    assign w_sum     = {1'b0, w_out_nxt} + {1'b0, w_q_nxt};
    assign w_room    = (w_sum < (CW+1)'(QDEPTH));

    assign inst_req  = r_req;
    assign inst_addr = r_fpc;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_RUN;
        else         r_state <= w_state_nxt;
    end

    // FSM next state: redirect against an unaccepted request parks it in HOLD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:  if (redirect_valid && r_req && !inst_addr_ok) w_state_nxt = S_HOLD;
            S_HOLD: if (inst_addr_ok)                             w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_in_hold = (r_state == S_HOLD);
    end

    // Fetch PC, saved redirect target and the held request line
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fpc     <= RESET_PC;
            r_hold_pc <= '0;
            r_req     <= 1'b0;
        end else begin
            if (w_in_hold) begin
                if (redirect_valid) r_hold_pc <= redirect_pc;
                if (w_acc)          r_fpc     <= redirect_valid ? redirect_pc : r_hold_pc;
            end else if (redirect_valid) begin
                if (r_req && !inst_addr_ok) r_hold_pc <= redirect_pc;
                else                        r_fpc     <= redirect_pc;
            end else if (w_acc) begin
                r_fpc <= r_fpc + 32'd4;
            end
            r_req <= (r_req & ~inst_addr_ok) | w_room;
        end
    end

    // Outstanding/discard counters and FIFO pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_cnt <= '0;
            r_dc      <= '0;
            r_q_cnt   <= '0;
            r_pf_wp   <= '0;
            r_pf_rp   <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
        end else begin
            r_out_cnt <= w_out_nxt;
            r_dc      <= w_dc_nxt;
            r_q_cnt   <= w_q_nxt;
            if (w_acc)        r_pf_wp <= r_pf_wp + AW'(1);
            if (inst_data_ok) r_pf_rp <= r_pf_rp + AW'(1);
            if (redirect_valid) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop)  r_rp <= r_rp + AW'(1);
            end
        end
    end

    // FIFO storage; contents are qualified by the counters, so no reset
    always_ff @(posedge clk) begin
        if (w_acc) r_pcf[r_pf_wp] <= r_fpc;
        if (w_push) begin
            r_qpc[r_wp]  <= w_head_pc;
            r_qins[r_wp] <= inst_rdata;
        end
    end

    // Decoder view: queue head, or the returning word when bypassing
    always_comb begin
        dec_valid = ~w_q_empty;
        dec_pc    = w_q_empty ? 32'd0 : r_qpc[r_rp];
        dec_instr = w_q_empty ? 32'd0 : r_qins[r_rp];
        if (w_byp) begin
            dec_valid = 1'b1;
            dec_pc    = w_head_pc;
            dec_instr = inst_rdata;
        end
    end
endmodule
